// File: rtl/one_hot_ptr_fifo_pkg.sv
// Shared helpers for the one-hot pointer FIFO.
package one_hot_ptr_fifo_pkg;

    localparam int unsigned MAX_PTR_W = 32;

    // Rotate the low `width` bits of vec left by one; bits above width come back as zero.
    function automatic logic [MAX_PTR_W-1:0] ptr_rotl(input logic [MAX_PTR_W-1:0] vec,
                                                      input int unsigned width);
        logic [MAX_PTR_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_PTR_W; i++) begin
            if (i < width) begin
                r[5'((i + 1 == width) ? 0 : i + 1)] = vec[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/one_hot_ptr_fifo_rotator.sv
// One-hot pointer register: resets to entry 0 and rotates left when en is high.
module one_hot_ptr_rotator
    import one_hot_ptr_fifo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);

    generate
        if (WIDTH == 1) begin : g_single
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, rst, en};
            assign ptr = 1'b1;
        end else begin : g_rot
            logic [WIDTH-1:0] ptr_q;
            logic [WIDTH-1:0] ptr_d;

            always_comb begin
                ptr_d = ptr_q;
                if (en) begin
                    ptr_d = WIDTH'(ptr_rotl(MAX_PTR_W'(ptr_q), WIDTH));
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ptr_q <= WIDTH'(1);
                end else begin
                    ptr_q <= ptr_d;
                end
            end

            assign ptr = ptr_q;
        end
    endgenerate

endmodule

// File: rtl/one_hot_ptr_fifo.sv
// Shallow FIFO with rotating one-hot read/write pointers and an AND-OR read mux.
module one_hot_ptr_fifo
    import one_hot_ptr_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]      wr_ptr;
    logic [DEPTH-1:0]      rd_ptr;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  push_acc, pop_acc;

    assign valid    = (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    assign push_acc = push & (~full | pop);
    assign pop_acc  = pop & valid;

    one_hot_ptr_rotator #(.WIDTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (push_acc),
        .ptr (wr_ptr)
    );

    one_hot_ptr_rotator #(.WIDTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (pop_acc),
        .ptr (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        if (push_acc && !pop_acc) begin
            count_d = count_q + CW'(1);
        end else if (pop_acc && !push_acc) begin
            count_d = count_q - CW'(1);
        end
        overflow_d  = push & full & ~pop;
        underflow_d = pop & ~valid;
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (push_acc && wr_ptr[i]) begin
                mem_d[i] = data_in;
            end
        end
    end

    always_comb begin
        data_out = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            data_out = data_out | (mem_q[i] & {DATA_WIDTH{rd_ptr[i]}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; contents are only visible through a valid head.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    a_wr_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(wr_ptr));
    a_rd_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(rd_ptr));
    a_count_max: assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));
    a_full_ptrs: assert property (@(posedge clk) disable iff (rst) full |-> (wr_ptr == rd_ptr));
    a_empty_ptrs: assert property (@(posedge clk) disable iff (rst) !valid |-> (wr_ptr == rd_ptr));

endmodule

// File: tb/tb_one_hot_ptr_fifo.sv
// Bench for one_hot_ptr_fifo: directed scenarios on DEPTH=4, random queue-model runs on DEPTH=4/3/1.
module tb_one_hot_ptr_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push_v      [3];
    logic        pop_v       [3];
    logic [31:0] din_v       [3];
    logic [31:0] dout_v      [3];
    logic        valid_v     [3];
    logic        full_v      [3];
    logic        overflow_v  [3];
    logic        underflow_v [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    one_hot_ptr_fifo #(.DATA_WIDTH(32), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .push(push_v[0]), .data_in(din_v[0]), .pop(pop_v[0]),
        .data_out(dout_v[0]), .valid(valid_v[0]), .full(full_v[0]),
        .overflow(overflow_v[0]), .underflow(underflow_v[0])
    );

    one_hot_ptr_fifo #(.DATA_WIDTH(32), .DEPTH(3)) u3 (
        .clk(clk), .rst(rst), .push(push_v[1]), .data_in(din_v[1]), .pop(pop_v[1]),
        .data_out(dout_v[1]), .valid(valid_v[1]), .full(full_v[1]),
        .overflow(overflow_v[1]), .underflow(underflow_v[1])
    );

    one_hot_ptr_fifo #(.DATA_WIDTH(32), .DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .push(push_v[2]), .data_in(din_v[2]), .pop(pop_v[2]),
        .data_out(dout_v[2]), .valid(valid_v[2]), .full(full_v[2]),
        .overflow(overflow_v[2]), .underflow(underflow_v[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            push_v[k] = 1'b0;
            pop_v[k]  = 1'b0;
            din_v[k]  = '0;
        end
    endtask

    task automatic drive4(input logic p, input logic q, input logic [31:0] d);
        push_v[0] = p;
        pop_v[0]  = q;
        din_v[0]  = d;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({valid_v[0], full_v[0], overflow_v[0], underflow_v[0]} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got v/f/o/u=%b%b%b%b want 0000",
                     valid_v[0], full_v[0], overflow_v[0], underflow_v[0]);
        end
        checks++;
        if (u4.wr_ptr !== 4'b0001 || u4.rd_ptr !== 4'b0001) begin
            failures++;
            $display("FAIL reset_ptrs: got wr=%b rd=%b want 0001/0001", u4.wr_ptr, u4.rd_ptr);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, 1'b0, 32'hA0 + 32'(i));
            tick();
        end
        checks++;
        if (full_v[0] !== 1'b1 || valid_v[0] !== 1'b1 || dout_v[0] !== 32'hA0) begin
            failures++;
            $display("FAIL fill: got full=%b valid=%b dout=%h want 1 1 000000a0",
                     full_v[0], valid_v[0], dout_v[0]);
        end
        drive4(1'b1, 1'b0, 32'hFF);
        tick();
        checks++;
        if (overflow_v[0] !== 1'b1 || full_v[0] !== 1'b1 || dout_v[0] !== 32'hA0) begin
            failures++;
            $display("FAIL overflow_pulse: got ovf=%b full=%b dout=%h want 1 1 000000a0",
                     overflow_v[0], full_v[0], dout_v[0]);
        end
        drive4(1'b0, 1'b0, '0);
        tick();
        checks++;
        if (overflow_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear: got %b want 0", overflow_v[0]);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'hA1;
        exp_seq[1] = 32'hA2;
        exp_seq[2] = 32'hA3;
        exp_seq[3] = 32'hB0;
        drive4(1'b1, 1'b1, 32'hB0);
        tick();
        checks++;
        if (u4.count_q !== 3'd4 || full_v[0] !== 1'b1 || dout_v[0] !== 32'hA1 || overflow_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL full_push_pop: got count=%0d full=%b dout=%h ovf=%b want 4 1 000000a1 0",
                     u4.count_q, full_v[0], dout_v[0], overflow_v[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout_v[0] !== exp_seq[i]) begin
                failures++;
                $display("FAIL wrap_pop%0d: got %h want %h", i, dout_v[0], exp_seq[i]);
            end
            drive4(1'b0, 1'b1, '0);
            tick();
        end
        drive4(1'b0, 1'b0, '0);
        checks++;
        if (valid_v[0] !== 1'b0 || underflow_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL drained: got valid=%b udf=%b want 0 0", valid_v[0], underflow_v[0]);
        end
    endtask

    task automatic test_underflow();
        drive4(1'b0, 1'b1, '0);
        tick();
        checks++;
        if (underflow_v[0] !== 1'b1 || valid_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL underflow_pulse: got udf=%b valid=%b want 1 0", underflow_v[0], valid_v[0]);
        end
        drive4(1'b0, 1'b0, '0);
        tick();
        checks++;
        if (underflow_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clear: got %b want 0", underflow_v[0]);
        end
        drive4(1'b1, 1'b1, 32'hC0);
        tick();
        drive4(1'b0, 1'b0, '0);
        checks++;
        if (valid_v[0] !== 1'b1 || dout_v[0] !== 32'hC0 || underflow_v[0] !== 1'b1 || u4.count_q !== 3'd1) begin
            failures++;
            $display("FAIL empty_push_pop: got valid=%b dout=%h udf=%b count=%0d want 1 000000c0 1 1",
                     valid_v[0], dout_v[0], underflow_v[0], u4.count_q);
        end
    endtask

    task automatic test_async_reset();
        drive4(1'b1, 1'b0, 32'hD0);
        tick();
        drive4(1'b1, 1'b0, 32'hD1);
        tick();
        drive4(1'b0, 1'b0, '0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (valid_v[0] !== 1'b0 || u4.wr_ptr !== 4'b0001 || u4.rd_ptr !== 4'b0001) begin
            failures++;
            $display("FAIL async_reset: got valid=%b wr=%b rd=%b want 0 0001 0001",
                     valid_v[0], u4.wr_ptr, u4.rd_ptr);
        end
        #1 rst = 1'b0;
        tick();
        drive4(1'b1, 1'b0, 32'hE0);
        tick();
        drive4(1'b0, 1'b0, '0);
        checks++;
        if (valid_v[0] !== 1'b1 || dout_v[0] !== 32'hE0 || u4.count_q !== 3'd1) begin
            failures++;
            $display("FAIL post_reset_push: got valid=%b dout=%h count=%0d want 1 000000e0 1",
                     valid_v[0], dout_v[0], u4.count_q);
        end
    endtask

    task automatic test_random(input int k, input int depth, input int cycles);
        logic [31:0] q [$];
        logic        p, r, exp_ovf, exp_udf;
        logic [31:0] d;
        int          bad;
        bad = 0;
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int c = 0; c < cycles; c++) begin
            p = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            d = $urandom;
            push_v[k] = p;
            pop_v[k]  = r;
            din_v[k]  = d;
            exp_ovf = p && (q.size() == depth) && !r;
            exp_udf = r && (q.size() == 0);
            if (r && q.size() > 0) void'(q.pop_front());
            else if (p && r && q.size() == 0) begin end
            if (p && (q.size() < depth)) q.push_back(d);
            tick();
            checks++;
            if (valid_v[k] !== (q.size() != 0) || full_v[k] !== (q.size() == depth) ||
                overflow_v[k] !== exp_ovf || underflow_v[k] !== exp_udf ||
                (q.size() != 0 && dout_v[k] !== q[0])) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_d%0d cycle %0d: got v=%b f=%b o=%b u=%b dout=%h want v=%b f=%b o=%b u=%b head=%h",
                             depth, c, valid_v[k], full_v[k], overflow_v[k], underflow_v[k], dout_v[k],
                             (q.size() != 0), (q.size() == depth), exp_ovf, exp_udf,
                             (q.size() != 0) ? q[0] : 32'h0);
            end
        end
        idle_all();
        tick();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_fill_overflow();
        test_full_push_pop();
        test_underflow();
        test_async_reset();
        test_random(0, 4, 1000);
        test_random(1, 3, 1000);
        test_random(2, 1, 1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
